// File: rtl/bamse_bus_master.sv
// bamse_bus_master: initiator for the BAMSE 8-bit peripheral register bus.
// Queues write/read commands in a small FIFO and drives address/data_out with
// one SETUP cycle followed by a wen/ren strobe of STROBE_CYCLES cycles. Reads
// wait RD_LAT cycles after the strobe before data_in is sampled, then they are
// returned on a valid/ready response port.
//
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready               command handshake (ready = FIFO not full)
//   cmd_write/cmd_addr/cmd_wdata      command payload
//   rsp_valid/rsp_ready               read response handshake
//   rsp_addr/rsp_rdata                read response payload
//   address/data_out/data_in          peripheral bus address and data
//   wen/ren                           peripheral write/read strobes
//   busy                              FSM active or commands queued
//   irq/irq_ack/irq_pending           interrupt latch (optional)
//
// Optional feature macro: BAMSE_MASTER_IRQ_EN. When it is defined, irq is
// synchronised and its rising edge latches irq_pending; otherwise
// irq_pending is tied low and irq/irq_ack are ignored.

module bamse_bus_master #(
    parameter int unsigned CMD_DEPTH     = 4,
    parameter int unsigned STROBE_CYCLES = 1,
    parameter int unsigned RD_LAT        = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_addr,
    output logic [7:0] rsp_rdata,
    output logic [7:0] address,
    output logic [7:0] data_out,
    input  logic [7:0] data_in,
    output logic       wen,
    output logic       ren,
    output logic       busy,
    input  logic       irq,
    input  logic       irq_ack,
    output logic       irq_pending
);

    localparam int unsigned AW = $clog2(CMD_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } state_t;

    cmd_t          fifo_mem [CMD_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    cmd_t          head;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          is_write;
    logic          sample;

    // FIFO status: extra pointer MSB distinguishes full from empty
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign head      = fifo_mem[rd_ptr[AW-1:0]];
    assign busy      = (state != IDLE) || !empty;

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
        end
    end

    // Next-state logic; cnt counts down the remaining cycles of STROBE/WAIT
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pop       = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                state_nxt = STROBE;
                cnt_nxt   = CW'(STROBE_CYCLES - 1);
            end
            STROBE: begin
                if (cnt == '0) begin
                    if (is_write) begin
                        state_nxt = IDLE;
                    end else if (RD_LAT == 0) begin
                        sample    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(RD_LAT - 1);
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointers and registered bus/response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            is_write  <= 1'b0;
            address   <= '0;
            data_out  <= '0;
            wen       <= 1'b0;
            ren       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                is_write <= head.write;
                address  <= head.addr;
                data_out <= head.wdata;
            end
            // is_write is already stable when STROBE is entered from SETUP
            wen       <= (state_nxt == STROBE) && is_write;
            ren       <= (state_nxt == STROBE) && !is_write;
            rsp_valid <= (state_nxt == RESP);
            if (sample) begin
                rsp_rdata <= data_in;
                rsp_addr  <= address;
            end
        end
    end

`ifdef BAMSE_MASTER_IRQ_EN
    // Two-flop synchroniser plus one delay flop for rising-edge detection
    logic [2:0] irq_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync    <= '0;
            irq_pending <= 1'b0;
        end else begin
            irq_sync <= {irq_sync[1:0], irq};
            // A new edge wins over a coincident acknowledge
            if (irq_sync[1] && !irq_sync[2]) begin
                irq_pending <= 1'b1;
            end else if (irq_ack) begin
                irq_pending <= 1'b0;
            end
        end
    end
`else
    logic irq_unused;
    assign irq_unused  = irq ^ irq_ack;
    assign irq_pending = 1'b0;
`endif

endmodule

// File: tb/tb_bamse_bus_master.sv
// Scoreboard bench for bamse_bus_master. Stimulus pushes expected bus strobes
// and read responses into queues; monitors pop and compare whenever the DUT
// strobes the bus or completes a response handshake. Instance a uses
// STROBE_CYCLES=1/RD_LAT=1, instance b uses STROBE_CYCLES=3/RD_LAT=2.

module tb_bamse_bus_master;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // instance a
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_addr, rsp_rdata;
    logic [7:0] address, data_out, data_in;
    logic       wen, ren, busy, irq, irq_ack, irq_pending;

    // instance b
    logic       b_cmd_valid, b_cmd_ready;
    logic       b_rsp_valid, b_rsp_ready;
    logic [7:0] b_rsp_addr, b_rsp_rdata;
    logic [7:0] b_address, b_data_out, b_data_in;
    logic       b_wen, b_ren, b_busy, b_irq_pending;

    // simple responder: each register reads back as its address xor 0x01
    assign data_in = address ^ 8'h01;

    bamse_bus_master #(.CMD_DEPTH(4), .STROBE_CYCLES(1), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
        .address(address), .data_out(data_out), .data_in(data_in),
        .wen(wen), .ren(ren), .busy(busy),
        .irq(irq), .irq_ack(irq_ack), .irq_pending(irq_pending)
    );

    bamse_bus_master #(.CMD_DEPTH(4), .STROBE_CYCLES(3), .RD_LAT(2)) dut_b (
        .clk(clk), .rst(rst),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(1'b0),
        .cmd_addr(8'h30), .cmd_wdata(8'h00),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_addr(b_rsp_addr), .rsp_rdata(b_rsp_rdata),
        .address(b_address), .data_out(b_data_out), .data_in(b_data_in),
        .wen(b_wen), .ren(b_ren), .busy(b_busy),
        .irq(1'b0), .irq_ack(1'b0), .irq_pending(b_irq_pending)
    );

    typedef struct {
        logic       w;
        logic [7:0] a;
        logic [7:0] d;
    } bus_t;

    bus_t        bus_q[$];
    logic [15:0] rsp_q[$];
    logic [15:0] b_rsp_q[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out @%0t", name, $time);
    endtask

    // bus and response monitor for instance a
    always @(negedge clk) begin
        if (!rst) begin
            if (wen || ren) begin
                chk("strobe_exclusive", 32'(wen & ren), 32'd0);
                if (bus_q.size() == 0) begin
                    timeout_fail("bus_unexpected_strobe");
                end else begin
                    bus_t e;
                    e = bus_q.pop_front();
                    chk("bus_kind", 32'(wen), 32'(e.w));
                    chk("bus_addr", 32'(address), 32'(e.a));
                    if (e.w) chk("bus_wdata", 32'(data_out), 32'(e.d));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    timeout_fail("rsp_unexpected");
                end else begin
                    logic [15:0] r;
                    r = rsp_q.pop_front();
                    chk("rsp_addr", 32'(rsp_addr), 32'(r[15:8]));
                    chk("rsp_rdata", 32'(rsp_rdata), 32'(r[7:0]));
                end
            end
        end
    end

    // response monitor for instance b
    always @(negedge clk) begin
        if (!rst && b_rsp_valid && b_rsp_ready) begin
            if (b_rsp_q.size() == 0) begin
                timeout_fail("b_rsp_unexpected");
            end else begin
                logic [15:0] r;
                r = b_rsp_q.pop_front();
                chk("b_rsp_addr", 32'(b_rsp_addr), 32'(r[15:8]));
                chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(r[7:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // offer one command to instance a and register its expected effects
    task automatic push_a(input logic w, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rdata);
        int n;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout_fail("push_accept");
        bus_q.push_back('{w: w, a: a, d: d});
        if (!w) rsp_q.push_back({a, exp_rdata});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout_fail("wait_idle");
        tick();
    endtask

    task automatic wait_rsp_valid_a();
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) timeout_fail("wait_rsp_valid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus_t cmds[5];
        int   n;

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; irq = 1'b0; irq_ack = 1'b0;
        b_cmd_valid = 1'b0; b_rsp_ready = 1'b1; b_data_in = 8'h55;
        repeat (3) @(posedge clk);

        // reset values
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_ren", 32'(ren), 32'd0);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq_pending", 32'(irq_pending), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // single write: wen in the third cycle after the accepting cycle
        push_a(1'b1, 8'h00, 8'h36, 8'h00);
        @(negedge clk);
        chk("t1_idle_wen", 32'(wen), 32'd0);
        @(negedge clk);
        chk("t1_setup_wen", 32'(wen), 32'd0);
        chk("t1_setup_addr", 32'(address), 32'h00);
        chk("t1_setup_data", 32'(data_out), 32'h36);
        @(negedge clk);
        chk("t1_strobe_wen", 32'(wen), 32'd1);
        chk("t1_strobe_data", 32'(data_out), 32'h36);
        @(negedge clk);
        chk("t1_after_wen", 32'(wen), 32'd0);
        wait_idle_a();

        // read with stalled response; queued write must wait for the handshake
        rsp_ready = 1'b0;
        push_a(1'b0, 8'h00, 8'h00, 8'h01);
        push_a(1'b1, 8'h05, 8'h77, 8'h00);
        wait_rsp_valid_a();
        for (int i = 0; i < 5; i++) begin
            chk("t2_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t2_rsp_rdata", 32'(rsp_rdata), 32'h01);
            chk("t2_rsp_addr", 32'(rsp_addr), 32'h00);
            chk("t2_no_wen", 32'(wen), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle_a();

        // fill the FIFO behind a stalled read; fifth command is refused
        rsp_ready = 1'b0;
        push_a(1'b0, 8'h10, 8'h00, 8'h11);
        wait_rsp_valid_a();
        tick();
        cmds[0] = '{w: 1'b1, a: 8'h20, d: 8'hA1};
        cmds[1] = '{w: 1'b0, a: 8'h21, d: 8'h00};
        cmds[2] = '{w: 1'b1, a: 8'h22, d: 8'hA3};
        cmds[3] = '{w: 1'b0, a: 8'h23, d: 8'h00};
        cmds[4] = '{w: 1'b1, a: 8'h24, d: 8'hA5};
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_write = cmds[i].w;
            cmd_addr  = cmds[i].a;
            cmd_wdata = cmds[i].d;
            @(negedge clk);
            chk("t3_cmd_ready", 32'(cmd_ready), 32'(i < 4));
            if (i < 4) begin
                bus_q.push_back(cmds[i]);
                if (!cmds[i].w) rsp_q.push_back({cmds[i].a, cmds[i].a ^ 8'h01});
            end
            tick();
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("t3_full_ready", 32'(cmd_ready), 32'd0);
        chk("t3_full_busy", 32'(busy), 32'd1);
        tick();
        rsp_ready = 1'b1;
        wait_idle_a();
        chk("t3_bus_drained", 32'(bus_q.size()), 32'd0);
        chk("t3_rsp_drained", 32'(rsp_q.size()), 32'd0);

        // instance b: 3-cycle ren, data_in changes on the last WAIT cycle
        b_cmd_valid = 1'b1;
        b_rsp_q.push_back({8'h30, 8'hAA});
        tick();
        b_cmd_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!b_ren && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!b_ren) timeout_fail("t4_wait_ren");
        n = 0;
        while (b_ren && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("t4_ren_cycles", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        b_data_in = 8'hAA;
        n = 0;
        @(negedge clk);
        while (b_busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (b_busy) timeout_fail("t4_wait_idle");
        chk("t4_b_rsp_drained", 32'(b_rsp_q.size()), 32'd0);

        // reset during a write strobe with a read queued behind it
        tick();
        push_a(1'b1, 8'h40, 8'h5A, 8'h00);
        push_a(1'b0, 8'h41, 8'h00, 8'h40);
        n = 0;
        @(negedge clk);
        while (!wen && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!wen) timeout_fail("t5_wait_wen");
        #1;
        rst = 1'b1;
        #1;
        chk("t5_wen", 32'(wen), 32'd0);
        chk("t5_ren", 32'(ren), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t5_address", 32'(address), 32'd0);
        chk("t5_data_out", 32'(data_out), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        bus_q.delete();
        rsp_q.delete();
        tick();
        rst = 1'b0;
        repeat (15) tick();
        chk("t5_still_idle", 32'(busy), 32'd0);

        // interrupt latch
`ifdef BAMSE_MASTER_IRQ_EN
        irq = 1'b1;
        tick();
        irq = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t6_irq_set", 32'(irq_pending), 32'd1);
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        @(negedge clk);
        chk("t6_irq_cleared", 32'(irq_pending), 32'd0);
        tick();
        // edge reaches the latch on the same clock as the ack
        irq = 1'b1;
        tick();
        irq = 1'b0;
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        @(negedge clk);
        chk("t6_set_wins", 32'(irq_pending), 32'd1);
        tick();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        @(negedge clk);
        chk("t6_final_clear", 32'(irq_pending), 32'd0);
`else
        irq = 1'b1;
        tick();
        irq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_irq_tied_low", 32'(irq_pending), 32'd0);
        end
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bamse_bus_master.md
Name: bamse_bus_master

Overview:
- Initiator side of the BAMSE 8-bit peripheral register bus.
- Timer and other peripherals on this bus are responders; this block drives them.
- Accepts queued write/read commands through a valid/ready port and drives address, write data, wen and ren with fixed setup/strobe timing.
- Samples read data and returns it on a valid/ready response port. Sits between a host sequencer (or test harness) and the peripheral bus.

Parameters:
- CMD_DEPTH, 4, command FIFO depth; power of two, 2..16.
- STROBE_CYCLES, 1, cycles wen/ren held high; 1..15.
- RD_LAT, 1, cycles after ren deasserts before data_in is sampled; 0..7.

Ports:
- clk  in  1  single system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  target register address.
- cmd_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  read response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_addr  out  8  address of the returned read.
- rsp_rdata  out  8  sampled read data.
- address  out  8  bus address.
- data_out  out  8  bus write data; connects to peripheral config_in.
- data_in  in  8  bus read data; OR of peripheral config_out.
- wen  out  1  write strobe.
- ren  out  1  read strobe.
- busy  out  1  FSM not IDLE, or FIFO not empty.
- irq  in  1  peripheral interrupt (optional feature).
- irq_ack  in  1  clears irq_pending (optional feature).
- irq_pending  out  1  latched interrupt (optional feature).

Behaviour:
- Reset: asserting rst immediately drives these outputs to 0 and empties the FIFO: wen, ren, address, data_out, rsp_valid, rsp_addr, rsp_rdata, irq_pending, busy. cmd_ready = 1 after reset.
- Reset mid-transaction: the in-flight command is aborted and discarded. No partial strobe is extended.
- FIFO push: occurs when cmd_valid && cmd_ready.
- FIFO pop: occurs when the FSM leaves IDLE.
- Simultaneous push and pop when full: the push is refused, because cmd_ready is already 0 that cycle. Push into an empty FIFO becomes visible to the FSM the next cycle.
- Pointers: log2(CMD_DEPTH)+1 bits wide; pointers wrap modulo 2*CMD_DEPTH.
- State IDLE: if the FIFO is non-empty, pop it, load address and data_out, and go to SETUP.
- State SETUP: lasts 1 cycle; address and data stable, strobes low. Then go to STROBE.
- State STROBE: wen (write) or ren (read) high for exactly STROBE_CYCLES cycles. Then a write goes to IDLE; a read goes to WAIT.
- State WAIT: lasts RD_LAT cycles with strobes low; if RD_LAT = 0 the state is skipped. At the end of WAIT, data_in is sampled into rsp_rdata, and rsp_addr is loaded; then go to RESP.
- State RESP: rsp_valid = 1; stay until rsp_ready. On the handshake clear rsp_valid and go to IDLE.
- Response stall: a stalled response stalls the bus; later commands stay queued.
- Address and data_out hold their last values in IDLE. They never change while wen or ren is high.
- wen and ren are never high together.
- Write latency, command accepted into an empty FIFO to first wen cycle: 3 clocks.
- Back-to-back writes: period is 2 + STROBE_CYCLES cycles.
- busy is combinational from state and FIFO count.

Optional Feature:
- Macro: BAMSE_MASTER_IRQ_EN.
- Defined:
  - irq passes through a 2-flop synchronizer; a rising edge sets irq_pending.
  - irq_ack clears irq_pending.
  - If a new edge and irq_ack land in the same cycle, the set wins and irq_pending stays 1.
- Undefined: irq and irq_ack are ignored, irq_pending is tied 0, and no synchronizer flops exist.

Test Plan:
- Reset at STROBE_CYCLES=1: one write, addr 0x00, data 0x36. Expect wen high for exactly 1 cycle, 3 cycles after acceptance, with address=0x00 and data_out=0x36 stable from SETUP through STROBE.
- Read addr 0x00 with data_in=0x01 and rsp_ready held 0 for 5 cycles. Expect rsp_valid=1, rsp_rdata=0x01, rsp_addr=0x00, held stable until rsp_ready. A queued write behind it must not strobe before the response handshake.
- Push 5 commands at CMD_DEPTH=4 with the bus stalled by an unacknowledged read. Expect cmd_ready=0 after 4 are accepted, the 5th refused, and all accepted commands executed in order.
- STROBE_CYCLES=3, RD_LAT=2, data_in changes 0x55→0xAA on the last WAIT cycle. Expect ren high for 3 cycles and rsp_rdata=0xAA.
- Assert rst during STROBE. Expect wen=0 the same instant, FIFO empty, busy=0, and no response generated.
- With BAMSE_MASTER_IRQ_EN, pulse irq for 1 cycle. Expect irq_pending=1 within 3 cycles, cleared by irq_ack. A coincident edge and ack leaves irq_pending=1. Without the macro, irq_pending stays 0.
